// File: rtl/tcore_param.sv
// Shared constants and types for the fetch-side predecode path.
//   OP_JAL / OP_JALR          : 32-bit major opcodes of the jump instructions
//   RVC_Q* / C_F3_* / F3_JALR : compressed quadrant and funct3 codes
//   predec_t                  : jump classification handed to the RAS
//   is_rvc()                  : halfword-is-compressed test
package tcore_param;

    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [2:0] F3_JALR  = 3'b000;

    localparam logic [1:0] RVC_Q0   = 2'b00;
    localparam logic [1:0] RVC_Q1   = 2'b01;
    localparam logic [1:0] RVC_Q2   = 2'b10;
    localparam logic [1:0] RVC_NONE = 2'b11;

    localparam logic [2:0] C_F3_JAL = 3'b001;
    localparam logic [2:0] C_F3_J   = 3'b101;
    localparam logic [2:0] C_F3_JR  = 3'b100;

    typedef struct packed {
        logic       is_comp;
        logic       j_type;
        logic       jr_type;
        logic [4:0] rd;
        logic [4:0] r1;
    } predec_t;

    // A halfword starts a compressed instruction unless its low bits are 11.
    function automatic logic is_rvc(input logic rvc_en, input logic [15:0] half);
        return rvc_en && (half[1:0] != RVC_NONE);
    endfunction

endpackage

// File: rtl/jump_predec.sv
// Combinational jump predecoder, shared between fetch alignment and decode.
// Ports:
//   i_inst     in  32  raw instruction (compressed form in [15:0])
//   i_is_comp  in   1  instruction is RVC
//   o_predec   out     {is_comp, j_type, jr_type, rd, r1}
module jump_predec
    import tcore_param::*;
(
    input  logic [31:0] i_inst,
    input  logic        i_is_comp,
    output predec_t     o_predec
);

    // Upper immediate bits carry no jump-class information.
    logic w_unused_hi;
    assign w_unused_hi = ^i_inst[31:20];

    // Classify the instruction as direct jump, indirect jump or neither.
    always_comb begin
        o_predec         = '0;
        o_predec.is_comp = i_is_comp;
        if (i_is_comp) begin
            case (i_inst[1:0])
                RVC_Q1: begin
                    case (i_inst[15:13])
                        C_F3_JAL: begin
                            o_predec.j_type = 1'b1;
                            o_predec.rd     = 5'd1;
                        end
                        C_F3_J: begin
                            o_predec.j_type = 1'b1;
                        end
                        default: o_predec.j_type = 1'b0;
                    endcase
                end
                RVC_Q2: begin
                    // C.JR/C.JALR need rs1!=0 and rs2==0; other encodings are C.MV/C.ADD/C.EBREAK.
                    if ((i_inst[15:13] == C_F3_JR) && (i_inst[11:7] != 5'd0) && (i_inst[6:2] == 5'd0)) begin
                        o_predec.jr_type = 1'b1;
                        o_predec.rd      = i_inst[12] ? 5'd1 : 5'd0;
                        o_predec.r1      = i_inst[11:7];
                    end else begin
                        o_predec.jr_type = 1'b0;
                    end
                end
                default: o_predec.j_type = 1'b0;
            endcase
        end else begin
            case (i_inst[6:0])
                OP_JAL: begin
                    o_predec.j_type = 1'b1;
                    o_predec.rd     = i_inst[11:7];
                end
                OP_JALR: begin
                    if (i_inst[14:12] == F3_JALR) begin
                        o_predec.jr_type = 1'b1;
                        o_predec.rd      = i_inst[11:7];
                        o_predec.r1      = i_inst[19:15];
                    end else begin
                        o_predec.jr_type = 1'b0;
                    end
                end
                default: o_predec.j_type = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/fetch_align_predecode.sv
// Fetch realigner: turns a stream of 32-bit fetch words (mixed RVC / 32-bit,
// possibly straddling word boundaries) into one aligned instruction per cycle,
// with jump predecode fields for the return-address stack.
// Ports:
//   clk_i, rst_i (sync, active high), flush_i (redirect)
//   fetch_valid_i / fetch_ready_o / fetch_pc_i / fetch_word_i : fetch side
//   inst_valid_o / inst_ready_i / inst_o / inst_pc_o           : instruction side
//   is_comp_o, j_type_o, jr_type_o, rd_addr_o, r1_addr_o, return_addr_o : predecode
module fetch_align_predecode
    import tcore_param::*;
#(
    parameter logic RVC_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_pc_i,
    input  logic [31:0] fetch_word_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        is_comp_o,
    output logic        j_type_o,
    output logic        jr_type_o,
    output logic [4:0]  rd_addr_o,
    output logic [4:0]  r1_addr_o,
    output logic [31:0] return_addr_o
);

    // Leftover-halfword buffer.
    logic [15:0] r_hbuf;
    logic [31:0] r_hbuf_pc;
    logic        r_hbuf_v;

    // Output register.
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_is_comp;
    logic        r_j_type;
    logic        r_jr_type;
    logic [4:0]  r_rd;
    logic [4:0]  r_r1;
    logic [31:0] r_ret;

    logic        w_ld;
    logic        w_hbuf_comp;
    logic        w_lo_comp;
    logic        w_hi_comp;
    logic        w_fetch_ready;
    logic        w_take;

    logic        w_emit;
    logic [31:0] w_emit_inst;
    logic [31:0] w_emit_pc;
    logic        w_emit_comp;
    logic [15:0] w_hbuf_nxt;
    logic [31:0] w_hbuf_pc_nxt;
    logic        w_hbuf_v_nxt;
    logic [31:0] w_emit_ret;
    predec_t     w_predec;

    assign w_ld        = !r_inst_valid || inst_ready_i;
    assign w_hbuf_comp = is_rvc(RVC_EN, r_hbuf);
    assign w_lo_comp   = is_rvc(RVC_EN, fetch_word_i[15:0]);
    assign w_hi_comp   = is_rvc(RVC_EN, fetch_word_i[31:16]);

    // A buffered RVC halfword is drained on its own, so no word is taken that cycle.
    assign w_fetch_ready = w_ld && !flush_i && !(r_hbuf_v && w_hbuf_comp);
    assign w_take        = fetch_valid_i && w_fetch_ready;
    assign fetch_ready_o = w_fetch_ready;

    // Select what to emit this cycle and what stays in the halfword buffer.
    always_comb begin
        w_emit        = 1'b0;
        w_emit_inst   = 32'h0000_0000;
        w_emit_pc     = r_hbuf_pc;
        w_emit_comp   = 1'b0;
        w_hbuf_nxt    = r_hbuf;
        w_hbuf_pc_nxt = r_hbuf_pc;
        w_hbuf_v_nxt  = r_hbuf_v;
        if (r_hbuf_v) begin
            if (w_hbuf_comp) begin
                w_emit       = 1'b1;
                w_emit_inst  = {16'h0000, r_hbuf};
                w_emit_comp  = 1'b1;
                w_hbuf_v_nxt = 1'b0;
            end else if (w_take) begin
                // Complete the straddler; the new word's upper half becomes the leftover.
                w_emit        = 1'b1;
                w_emit_inst   = {fetch_word_i[15:0], r_hbuf};
                w_hbuf_nxt    = fetch_word_i[31:16];
                w_hbuf_pc_nxt = r_hbuf_pc + 32'd4;
                w_hbuf_v_nxt  = 1'b1;
            end else begin
                w_emit = 1'b0;
            end
        end else if (w_take) begin
            w_emit_pc = fetch_pc_i;
            if (!fetch_pc_i[1]) begin
                if (w_lo_comp) begin
                    w_emit        = 1'b1;
                    w_emit_inst   = {16'h0000, fetch_word_i[15:0]};
                    w_emit_comp   = 1'b1;
                    w_hbuf_nxt    = fetch_word_i[31:16];
                    w_hbuf_pc_nxt = fetch_pc_i + 32'd2;
                    w_hbuf_v_nxt  = 1'b1;
                end else begin
                    w_emit      = 1'b1;
                    w_emit_inst = fetch_word_i;
                end
            end else begin
                if (w_hi_comp) begin
                    w_emit      = 1'b1;
                    w_emit_inst = {16'h0000, fetch_word_i[31:16]};
                    w_emit_comp = 1'b1;
                end else begin
                    // First half of a straddler: park it and wait for the next word.
                    w_hbuf_nxt    = fetch_word_i[31:16];
                    w_hbuf_pc_nxt = fetch_pc_i;
                    w_hbuf_v_nxt  = 1'b1;
                end
            end
        end else begin
            w_emit = 1'b0;
        end
    end

    assign w_emit_ret = w_emit_pc + (w_emit_comp ? 32'd2 : 32'd4);

    jump_predec u_jump_predec (
        .i_inst    (w_emit_inst),
        .i_is_comp (w_emit_comp),
        .o_predec  (w_predec)
    );

    // Halfword buffer state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hbuf    <= 16'h0000;
            r_hbuf_pc <= 32'h0000_0000;
            r_hbuf_v  <= 1'b0;
        end else if (flush_i) begin
            r_hbuf_v  <= 1'b0;
        end else if (w_ld) begin
            r_hbuf    <= w_hbuf_nxt;
            r_hbuf_pc <= w_hbuf_pc_nxt;
            r_hbuf_v  <= w_hbuf_v_nxt;
        end else begin
            r_hbuf_v  <= r_hbuf_v;
        end
    end

    // Output register; data fields only change when a new instruction is loaded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0000_0000;
            r_inst_pc    <= 32'h0000_0000;
            r_is_comp    <= 1'b0;
            r_j_type     <= 1'b0;
            r_jr_type    <= 1'b0;
            r_rd         <= 5'd0;
            r_r1         <= 5'd0;
            r_ret        <= 32'h0000_0000;
        end else if (flush_i) begin
            r_inst_valid <= 1'b0;
        end else if (w_ld) begin
            r_inst_valid <= w_emit;
            if (w_emit) begin
                r_inst    <= w_emit_inst;
                r_inst_pc <= w_emit_pc;
                r_is_comp <= w_predec.is_comp;
                r_j_type  <= w_predec.j_type;
                r_jr_type <= w_predec.jr_type;
                r_rd      <= w_predec.rd;
                r_r1      <= w_predec.r1;
                r_ret     <= w_emit_ret;
            end else begin
                r_inst    <= r_inst;
            end
        end else begin
            r_inst_valid <= r_inst_valid;
        end
    end

    assign inst_valid_o  = r_inst_valid;
    assign inst_o        = r_inst;
    assign inst_pc_o     = r_inst_pc;
    assign is_comp_o     = r_is_comp;
    assign j_type_o      = r_j_type;
    assign jr_type_o     = r_jr_type;
    assign rd_addr_o     = r_rd;
    assign r1_addr_o     = r_r1;
    assign return_addr_o = r_ret;

endmodule

// File: tb/tb_fetch_align_predecode.sv
// Self-checking bench for fetch_align_predecode: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// halfword-queue reference model.
module tb_fetch_align_predecode;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fv;
    logic        ir;
    logic [31:0] fpc;
    logic [31:0] fw;
    logic        fetch_ready_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        is_comp_o;
    logic        j_type_o;
    logic        jr_type_o;
    logic [4:0]  rd_addr_o;
    logic [4:0]  r1_addr_o;
    logic [31:0] return_addr_o;

    always #5 clk = ~clk;

    fetch_align_predecode #(.RVC_EN(1'b1)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .fetch_valid_i (fv),
        .fetch_ready_o (fetch_ready_o),
        .fetch_pc_i    (fpc),
        .fetch_word_i  (fw),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (ir),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .is_comp_o     (is_comp_o),
        .j_type_o      (j_type_o),
        .jr_type_o     (jr_type_o),
        .rd_addr_o     (rd_addr_o),
        .r1_addr_o     (r1_addr_o),
        .return_addr_o (return_addr_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] w,
                         input logic rdy, input logic fl);
        fv = v; fpc = pc; fw = w; ir = rdy; flush = fl;
    endtask

    task automatic chk_out(input string t, input logic [31:0] ins, input logic [31:0] pc,
                           input logic comp, input logic j, input logic jr,
                           input logic [4:0] rd, input logic [4:0] r1, input logic [31:0] ret);
        chk({t, ".valid"}, {31'd0, inst_valid_o}, 32'd1);
        chk({t, ".inst"}, inst_o, ins);
        chk({t, ".pc"}, inst_pc_o, pc);
        chk({t, ".cls"}, {19'd0, is_comp_o, j_type_o, jr_type_o, rd_addr_o, r1_addr_o},
            {19'd0, comp, j, jr, rd, r1});
        chk({t, ".ret"}, return_addr_o, ret);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       j;
        logic       jr;
        logic [4:0] rd;
        logic [4:0] r1;
    } rdec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    exp_t        pend[$];
    logic [15:0] hq[$];
    logic [31:0] hq_pc[$];
    logic [31:0] next_pc;

    function automatic rdec_t ref_dec(input logic [31:0] ins, input logic comp);
        rdec_t d;
        logic [15:0] h;
        d = '0;
        h = ins[15:0];
        if (comp) begin
            if (h[1:0] == 2'b01 && h[15:13] == 3'b001) begin
                d.j = 1'b1; d.rd = 5'd1;
            end else if (h[1:0] == 2'b01 && h[15:13] == 3'b101) begin
                d.j = 1'b1;
            end else if (h[1:0] == 2'b10 && h[15:13] == 3'b100 && h[11:7] != 5'd0 && h[6:2] == 5'd0) begin
                d.jr = 1'b1; d.rd = h[12] ? 5'd1 : 5'd0; d.r1 = h[11:7];
            end
        end else if (ins[6:0] == 7'h6F) begin
            d.j = 1'b1; d.rd = ins[11:7];
        end else if (ins[6:0] == 7'h67 && ins[14:12] == 3'd0) begin
            d.jr = 1'b1; d.rd = ins[11:7]; d.r1 = ins[19:15];
        end
        return d;
    endfunction

    // Pull every complete instruction out of the halfword queue, in program order.
    task automatic model_parse();
        exp_t e;
        while (hq.size() > 0) begin
            if (hq[0][1:0] != 2'b11) begin
                e.inst = {16'h0000, hq[0]}; e.pc = hq_pc[0]; e.comp = 1'b1;
                void'(hq.pop_front()); void'(hq_pc.pop_front());
                pend.push_back(e);
            end else if (hq.size() >= 2) begin
                e.inst = {hq[1], hq[0]}; e.pc = hq_pc[0]; e.comp = 1'b0;
                void'(hq.pop_front()); void'(hq_pc.pop_front());
                void'(hq.pop_front()); void'(hq_pc.pop_front());
                pend.push_back(e);
            end else begin
                break;
            end
        end
    endtask

    function automatic logic [15:0] rand_half();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return 16'h8082;
            1: return 16'h9082;
            2: return 16'h2005;
            3: return 16'hA001;
            4: return 16'h00EF;
            5: return 16'h8067;
            default: return r[15:0];
        endcase
    endfunction

    // One random-phase cycle: apply inputs, score the output handshake, feed the model.
    task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
        exp_t  e;
        rdec_t d;
        logic [31:0] r;
        @(negedge clk);
        drive(v, next_pc, w, rdy, fl);
        #1;
        if (inst_valid_o && ir) begin
            if (pend.size() == 0) begin
                chk("rnd.unexpected_inst", inst_o, 32'hxxxx_xxxx);
            end else begin
                e = pend.pop_front();
                d = ref_dec(e.inst, e.comp);
                chk("rnd.inst", inst_o, e.inst);
                chk("rnd.pc", inst_pc_o, e.pc);
                chk("rnd.cls", {19'd0, is_comp_o, j_type_o, jr_type_o, rd_addr_o, r1_addr_o},
                    {19'd0, e.comp, d.j, d.jr, d.rd, d.r1});
                chk("rnd.ret", return_addr_o, e.pc + (e.comp ? 32'd2 : 32'd4));
            end
        end
        if ((inst_valid_o && !ir) || fl) chk("rnd.ready_blocked", {31'd0, fetch_ready_o}, 32'd0);
        if (fv && fetch_ready_o) begin
            if (!fpc[1]) begin
                hq.push_back(fw[15:0]); hq_pc.push_back(fpc);
            end
            hq.push_back(fw[31:16]); hq_pc.push_back({fpc[31:2], 2'b10});
            model_parse();
            next_pc = {fpc[31:2], 2'b00} + 32'd4;
        end
        if (fl) begin
            pend.delete(); hq.delete(); hq_pc.delete();
            r = $urandom;
            next_pc = {16'h0000, r[15:1], 1'b0};
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_comp;
        logic        e_j;
        logic        e_jr;
        logic [4:0]  e_rd;
        logic [4:0]  e_r1;
        logic [31:0] e_ret;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{32'h0000_0100, 32'h0080_00EF, 32'h0080_00EF, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0,  32'h0000_0104};
        vt[1]  = '{32'h0000_0402, 32'h9082_0000, 32'h0000_9082, 32'h0000_0402, 1'b1, 1'b0, 1'b1, 5'd1, 5'd1,  32'h0000_0404};
        vt[2]  = '{32'h0000_0500, 32'h0007_80E7, 32'h0007_80E7, 32'h0000_0500, 1'b0, 1'b0, 1'b1, 5'd1, 5'd15, 32'h0000_0504};
        vt[3]  = '{32'h0000_0602, 32'hA001_0000, 32'h0000_A001, 32'h0000_0602, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0,  32'h0000_0604};
        vt[4]  = '{32'h0000_0702, 32'h2005_0000, 32'h0000_2005, 32'h0000_0702, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0,  32'h0000_0704};
        vt[5]  = '{32'h0000_0800, 32'h0000_0013, 32'h0000_0013, 32'h0000_0800, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0,  32'h0000_0804};
        vt[6]  = '{32'h0000_0900, 32'h0007_90E7, 32'h0007_90E7, 32'h0000_0900, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0,  32'h0000_0904};
        vt[7]  = '{32'h0000_0A02, 32'h8002_0000, 32'h0000_8002, 32'h0000_0A02, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0,  32'h0000_0A04};
        vt[8]  = '{32'h0000_0B02, 32'h8086_0000, 32'h0000_8086, 32'h0000_0B02, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0,  32'h0000_0B04};
        vt[9]  = '{32'hFFFF_FFFC, 32'h0000_006F, 32'h0000_006F, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0,  32'h0000_0000};
        vt[10] = '{32'hFFFF_FFFE, 32'h8082_0000, 32'h0000_8082, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 5'd0, 5'd1,  32'h0000_0000};

        // Reset state
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("reset.valid", {31'd0, inst_valid_o}, 32'd0);
        chk("reset.inst", inst_o, 32'h0);
        chk("reset.pc", inst_pc_o, 32'h0);
        chk("reset.ret", return_addr_o, 32'h0);
        chk("reset.cls", {19'd0, is_comp_o, j_type_o, jr_type_o, rd_addr_o, r1_addr_o}, 32'h0);
        rst = 1'b0;

        // Single-instruction words that leave the buffer empty
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(1'b1, vt[i].pc, vt[i].word, 1'b1, 1'b0);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vt[i].e_inst, vt[i].e_pc, vt[i].e_comp,
                    vt[i].e_j, vt[i].e_jr, vt[i].e_rd, vt[i].e_r1, vt[i].e_ret);
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d.no_extra", i), {31'd0, inst_valid_o}, 32'd0);
        end

        // Two RVC in one word
        drive(1'b1, 32'h200, 32'h8082_0001, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("rvc2.a", 32'h0001, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h202);
        chk("rvc2.ready_low", {31'd0, fetch_ready_o}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("rvc2.b", 32'h8082, 32'h202, 1'b1, 1'b0, 1'b1, 5'd0, 5'd1, 32'h204);
        @(negedge clk);
        chk("rvc2.empty", {31'd0, inst_valid_o}, 32'd0);

        // Straddling JALR
        drive(1'b1, 32'h300, 32'h8067_0001, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("strad.a", 32'h0001, 32'h300, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h302);
        drive(1'b1, 32'h304, 32'h0001_0000, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("strad.b", 32'h0000_8067, 32'h302, 1'b0, 1'b0, 1'b1, 5'd0, 5'd1, 32'h306);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("strad.c", 32'h0001, 32'h306, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h308);
        @(negedge clk);
        chk("strad.empty", {31'd0, inst_valid_o}, 32'd0);

        // Backpressure: three stalled cycles, then release
        drive(1'b1, 32'h200, 32'h8082_0001, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h204, 32'h0000_0013, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_out($sformatf("bp.hold%0d", k), 32'h0001, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h202);
            chk($sformatf("bp.ready%0d", k), {31'd0, fetch_ready_o}, 32'd0);
        end
        ir = 1'b1;
        @(negedge clk);
        chk_out("bp.rel1", 32'h8082, 32'h202, 1'b1, 1'b0, 1'b1, 5'd0, 5'd1, 32'h204);
        chk("bp.rel1_ready", {31'd0, fetch_ready_o}, 32'd1);
        @(negedge clk);
        chk_out("bp.rel2", 32'h0000_0013, 32'h204, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h208);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp.no_dup", {31'd0, inst_valid_o}, 32'd0);

        // Flush while the buffer holds the low half of a 32-bit instruction
        drive(1'b1, 32'h302, 32'h8067_0000, 1'b1, 1'b0);
        @(negedge clk);
        chk("fl.no_emit", {31'd0, inst_valid_o}, 32'd0);
        drive(1'b1, 32'h304, 32'h0001_0000, 1'b1, 1'b1);
        #1;
        chk("fl.ready_low", {31'd0, fetch_ready_o}, 32'd0);
        @(negedge clk);
        chk("fl.valid_low", {31'd0, inst_valid_o}, 32'd0);
        drive(1'b1, 32'h100, 32'h0080_00EF, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("fl.post", 32'h0080_00EF, 32'h100, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 32'h104);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("fl.empty", {31'd0, inst_valid_o}, 32'd0);

        // Reset in the middle of a two-RVC word
        drive(1'b1, 32'h200, 32'h8082_0001, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst.pre_valid", {31'd0, inst_valid_o}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst.inst", inst_o, 32'h0);
        chk("rst.pc", inst_pc_o, 32'h0);
        chk("rst.ret", return_addr_o, 32'h0);
        chk("rst.cls", {19'd0, is_comp_o, j_type_o, jr_type_o, rd_addr_o, r1_addr_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.hbuf_cleared", {31'd0, inst_valid_o}, 32'd0);

        // Randomized run against the halfword-queue model
        next_pc = 32'h0000_1000;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 9) < 7), {rand_half(), rand_half()},
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
        end
        for (int c = 0; c < 8; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("rnd.drained", pend.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
